// File: rtl/hack_alu_seq.sv
// hack_alu_seq
// Multi-cycle Hack instruction sequencer. It fetches instructions, holds the
// architectural A, D and PC registers, decodes C-instructions into the six
// ALU control bits and commits the external ALU's result to A, D and/or
// memory. It also resolves jumps from the ALU's zr/ng flags.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   instr_req/instr_addr     fetch request, address = PC
//   instr_valid/instr_data   fetch response (may arrive in the request cycle)
//   mem_rd_req/mem_addr      data read request, address = A[14:0]
//   mem_rvalid/mem_rdata     data read response
//   mem_we/mem_wdata         one-cycle write strobe for M destinations
//   alu_x/alu_y/alu_op       ALU operands and {no,f,ny,zy,nx,zx}, EXEC only
//   alu_result/alu_zr/alu_ng ALU outputs, captured at the end of EXEC
//   halted                   self-loop halt indication (optional feature)
//   pc_dbg/a_dbg/d_dbg       architectural state for observation
//
// Configuration
//   HACK_ALU_SEQ_HALT_EN : when defined, a taken jump to the jumping
//   instruction's own address parks the sequencer in HALT until reset.
//   When undefined, halted is tied low and self-loops keep fetching.
//
// Every interface output is a register. Each transition loads the output
// values that belong to the state being entered, so outputs change only on
// clock edges and on reset.

module hack_alu_seq (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req,
  output logic [14:0] instr_addr,
  input  logic        instr_valid,
  input  logic [15:0] instr_data,
  output logic        mem_rd_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic        halted,
  output logic [14:0] pc_dbg,
  output logic [15:0] a_dbg,
  output logic [15:0] d_dbg
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_MREAD,
    S_EXEC,
    S_WB
`ifdef HACK_ALU_SEQ_HALT_EN
    , S_HALT
`endif
  } state_t;

  state_t      r_state;
  logic [14:0] r_pc;
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [15:0] r_ir;
  logic [15:0] r_res;
  logic        r_zr;
  logic        r_ng;

  logic        r_instr_req;
  logic [14:0] r_instr_addr;
  logic        r_mem_rd_req;
  logic        r_mem_we;
  logic [14:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [15:0] r_alu_x;
  logic [15:0] r_alu_y;
  logic [5:0]  r_alu_op;

  logic        w_jump;
  logic [14:0] w_pc_inc;
  logic [14:0] w_pc_next;
  logic [5:0]  w_op;

  // Jump condition from the flags captured in EXEC; target is the old A.
  assign w_jump    = (r_ir[2] & r_ng) | (r_ir[1] & r_zr) | (r_ir[0] & ~r_ng & ~r_zr);
  assign w_pc_inc  = r_pc + 15'd1;
  assign w_pc_next = w_jump ? r_a[14:0] : w_pc_inc;
  // IR[11:6] are c1..c6 = zx,nx,zy,ny,f,no; the ALU wants zx in bit 0.
  assign w_op      = {r_ir[6], r_ir[7], r_ir[8], r_ir[9], r_ir[10], r_ir[11]};

  // Single state machine. All outputs default to idle each cycle and are
  // re-asserted for the state being entered (or held in a wait state).
  // The registered alu_y doubles as the M register: the read data is loaded
  // straight into it on the MREAD -> EXEC edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= '0;
      r_a          <= '0;
      r_d          <= '0;
      r_ir         <= '0;
      r_res        <= '0;
      r_zr         <= 1'b0;
      r_ng         <= 1'b0;
      r_instr_req  <= 1'b0;
      r_instr_addr <= '0;
      r_mem_rd_req <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_alu_x      <= '0;
      r_alu_y      <= '0;
      r_alu_op     <= '0;
    end else begin
      r_instr_req  <= 1'b0;
      r_instr_addr <= '0;
      r_mem_rd_req <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_alu_x      <= '0;
      r_alu_y      <= '0;
      r_alu_op     <= '0;
      case (r_state)
        S_BOOT: begin
          r_state      <= S_FETCH;
          r_instr_req  <= 1'b1;
          r_instr_addr <= r_pc;
        end
        S_FETCH: begin
          if (instr_valid) begin
            r_ir    <= instr_data;
            r_state <= S_DECODE;
          end else begin
            r_instr_req  <= 1'b1;
            r_instr_addr <= r_pc;
          end
        end
        S_DECODE: begin
          if (!r_ir[15]) begin
            r_a          <= {1'b0, r_ir[14:0]};
            r_pc         <= w_pc_inc;
            r_state      <= S_FETCH;
            r_instr_req  <= 1'b1;
            r_instr_addr <= w_pc_inc;
          end else if (r_ir[12]) begin
            r_state      <= S_MREAD;
            r_mem_rd_req <= 1'b1;
            r_mem_addr   <= r_a[14:0];
          end else begin
            r_state  <= S_EXEC;
            r_alu_x  <= r_d;
            r_alu_y  <= r_a;
            r_alu_op <= w_op;
          end
        end
        S_MREAD: begin
          if (mem_rvalid) begin
            r_state  <= S_EXEC;
            r_alu_x  <= r_d;
            r_alu_y  <= mem_rdata;
            r_alu_op <= w_op;
          end else begin
            r_mem_rd_req <= 1'b1;
            r_mem_addr   <= r_a[14:0];
          end
        end
        S_EXEC: begin
          r_res       <= alu_result;
          r_zr        <= alu_zr;
          r_ng        <= alu_ng;
          r_state     <= S_WB;
          r_mem_we    <= r_ir[3];
          r_mem_addr  <= r_ir[3] ? r_a[14:0] : 15'd0;
          r_mem_wdata <= r_ir[3] ? alu_result : 16'd0;
        end
        S_WB: begin
          if (r_ir[5]) r_a <= r_res;
          if (r_ir[4]) r_d <= r_res;
          r_pc <= w_pc_next;
`ifdef HACK_ALU_SEQ_HALT_EN
          if (w_jump && (r_a[14:0] == r_pc)) begin
            r_state <= S_HALT;
          end else begin
            r_state      <= S_FETCH;
            r_instr_req  <= 1'b1;
            r_instr_addr <= w_pc_next;
          end
`else
          r_state      <= S_FETCH;
          r_instr_req  <= 1'b1;
          r_instr_addr <= w_pc_next;
`endif
        end
`ifdef HACK_ALU_SEQ_HALT_EN
        S_HALT: r_state <= S_HALT;
`endif
        default: r_state <= S_BOOT;
      endcase
    end
  end

`ifdef HACK_ALU_SEQ_HALT_EN
  logic r_halted;

  // Halt flag follows the state register so it is registered like the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_halted <= 1'b0;
    else     r_halted <= (r_state == S_WB && w_jump && r_a[14:0] == r_pc) || r_halted;
  end

  assign halted = r_halted;
`else
  assign halted = 1'b0;
`endif

  assign instr_req  = r_instr_req;
  assign instr_addr = r_instr_addr;
  assign mem_rd_req = r_mem_rd_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign alu_x      = r_alu_x;
  assign alu_y      = r_alu_y;
  assign alu_op     = r_alu_op;
  assign pc_dbg     = r_pc;
  assign a_dbg      = r_a;
  assign d_dbg      = r_d;

endmodule

// File: tb/tb_hack_alu_seq.sv
// tb_hack_alu_seq
// Bench for hack_alu_seq. It plays instruction ROM, data RAM and the Hack
// ALU, and keeps an instruction-level model of the Hack machine (A, D, PC,
// RAM) that is stepped once per instruction and compared with the DUT.
// Directed steps reproduce the documented programs, then a run of random
// instructions with random response delays, then reset and halt scenarios.
// Define HACK_ALU_SEQ_HALT_EN for both bench and RTL to exercise HALT.

module tb_hack_alu_seq;

  logic        clk;
  logic        rst;
  logic        instr_req;
  logic [14:0] instr_addr;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic        mem_rd_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_zr;
  logic        alu_ng;
  logic        halted;
  logic [14:0] pc_dbg;
  logic [15:0] a_dbg;
  logic [15:0] d_dbg;

  int checks = 0;
  int errors = 0;

  // Instruction-level reference state
  logic [15:0] mRam [0:32767];
  logic [15:0] mA;
  logic [15:0] mD;
  logic [14:0] mPc;
  logic        expHalt;

  // The eighteen defined Hack computations (c1..c6)
  localparam logic [5:0] COMP_CODES [0:17] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

  hack_alu_seq dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .mem_rd_req(mem_rd_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .halted(halted), .pc_dbg(pc_dbg), .a_dbg(a_dbg), .d_dbg(d_dbg));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The Hack ALU the sequencer drives
  logic [15:0] ax, ay, ao;
  always_comb begin
    ax = alu_op[0] ? 16'd0 : alu_x;
    ax = alu_op[1] ? ~ax : ax;
    ay = alu_op[2] ? 16'd0 : alu_y;
    ay = alu_op[3] ? ~ay : ay;
    ao = alu_op[4] ? ax + ay : ax & ay;
    ao = alu_op[5] ? ~ao : ao;
    alu_result = ao;
    alu_zr = (ao == 16'd0);
    alu_ng = ao[15];
  end

  // Mnemonic-level meaning of each computation code
  function automatic logic [15:0] hackComp(input logic [5:0] c, input logic [15:0] d,
                                           input logic [15:0] m);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return d;
      6'b110000: return m;
      6'b001101: return ~d;
      6'b110001: return ~m;
      6'b001111: return 16'd0 - d;
      6'b110011: return 16'd0 - m;
      6'b011111: return d + 16'd1;
      6'b110111: return m + 16'd1;
      6'b001110: return d - 16'd1;
      6'b110010: return m - 16'd1;
      6'b000010: return d + m;
      6'b010011: return d - m;
      6'b000111: return m - d;
      6'b000000: return d & m;
      6'b010101: return d | m;
      default:   return 16'd0;
    endcase
  endfunction

  function automatic logic [87:0] outVec();
    return {instr_req, instr_addr, mem_rd_req, mem_we, mem_addr, mem_wdata,
            alu_x, alu_y, alu_op, halted};
  endfunction

  // Single comparison point: counts and reports on mismatch
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds reset for a few cycles, checks the idle state, releases at a negedge
  task automatic applyReset();
    rst = 1'b1;
    instr_valid = 1'b0;
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", outVec(), 0);
    checkOutput("reset_state", {pc_dbg, a_dbg, d_dbg}, 0);
    rst = 1'b0;
    mA = 16'd0;
    mD = 16'd0;
    mPc = 15'd0;
    expHalt = 1'b0;
  endtask

  // Serves one instruction (fetch + optional read), observes writeback,
  // steps the model and compares. Entered and left at a negedge.
  task automatic applyStimulus(input logic [15:0] instr, input int fWait, input int rWait);
    int cyc, expCyc, rdCnt, weCnt, overlap;
    logic [14:0] rdAddr, weAddr, target;
    logic [15:0] weData, y, res;
    logic [5:0] opOr, expOp;
    logic taken;
    cyc = 0;
    while (instr_req !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("fetch_seen", instr_req, 1'b1);
    checkOutput("fetch_addr", instr_addr, mPc);
    repeat (fWait) @(negedge clk);
    instr_valid = 1'b1;
    instr_data = instr;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data = 16'd0;
    cyc = fWait + 1;
    rdCnt = 0; weCnt = 0; overlap = 0; opOr = '0;
    rdAddr = '0; weAddr = '0; weData = '0;
    for (int k = 0; k < 40; k++) begin
      mem_rvalid = 1'b0;
      if (instr_req === 1'b1 || halted === 1'b1) break;
      if (mem_rd_req === 1'b1 && mem_we === 1'b1) overlap++;
      opOr |= alu_op;
      if (mem_we === 1'b1) begin
        weCnt++;
        weAddr = mem_addr;
        weData = mem_wdata;
      end
      if (mem_rd_req === 1'b1) begin
        if (rdCnt == 0) rdAddr = mem_addr;
        if (rdCnt >= rWait) begin
          mem_rvalid = 1'b1;
          mem_rdata = mRam[mA[14:0]];
        end
        rdCnt++;
      end
      @(negedge clk);
      cyc++;
    end
    mem_rvalid = 1'b0;
    checkOutput("instr_done", (instr_req === 1'b1) || (halted === 1'b1), 1'b1);

    if (!instr[15]) begin
      mA = {1'b0, instr[14:0]};
      mPc = mPc + 15'd1;
      expCyc = 2 + fWait;
      expOp = 6'd0;
    end else begin
      y = instr[12] ? mRam[mA[14:0]] : mA;
      res = hackComp(instr[11:6], mD, y);
      expOp = {instr[6], instr[7], instr[8], instr[9], instr[10], instr[11]};
      expCyc = instr[12] ? 5 + fWait + rWait : 4 + fWait;
      checkOutput("read_happened", rdCnt != 0, instr[12]);
      if (instr[12]) checkOutput("read_addr", rdAddr, mA[14:0]);
      checkOutput("write_count", weCnt, {31'd0, instr[3]});
      if (instr[3]) begin
        checkOutput("write_addr", weAddr, mA[14:0]);
        checkOutput("write_data", weData, res);
        mRam[mA[14:0]] = res;
      end
      taken = (instr[2] && $signed(res) < 0) || (instr[1] && res == 16'd0) ||
              (instr[0] && $signed(res) > 0);
      target = mA[14:0];
`ifdef HACK_ALU_SEQ_HALT_EN
      if (taken && target == mPc) expHalt = 1'b1;
`endif
      mPc = taken ? target : mPc + 15'd1;
      if (instr[5]) mA = res;
      if (instr[4]) mD = res;
    end
    checkOutput("rd_wr_overlap", overlap, 0);
    checkOutput("alu_op", opOr, expOp);
    checkOutput("halted", halted, expHalt);
    if (!expHalt) begin
      checkOutput("cycle_count", cyc, expCyc);
      checkOutput("pc", pc_dbg, mPc);
    end
    checkOutput("a_reg", a_dbg, mA);
    checkOutput("d_reg", d_dbg, mD);
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] instr;
    logic [2:0]  jmp;
    int fw, rw;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_data = 16'd0;
    mem_rvalid = 1'b0;
    mem_rdata = 16'd0;
    expHalt = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      r = $urandom;
      mRam[i] = r[15:0];
    end

    // @5 ; D=A
    applyReset();
    applyStimulus(16'h0005, 0, 0);
    applyStimulus(16'hEC10, 0, 0);
    checkOutput("dA_a", a_dbg, 16'd5);
    checkOutput("dA_d", d_dbg, 16'd5);
    checkOutput("dA_pc", pc_dbg, 15'd2);

    // @7 ; D=M ; M=D+1
    applyReset();
    mRam[7] = 16'h1234;
    applyStimulus(16'h0007, 0, 0);
    applyStimulus(16'hFC10, 0, 0);
    checkOutput("dM_d", d_dbg, 16'h1234);
    applyStimulus(16'hE7C8, 0, 0);
    checkOutput("mInc_ram", mRam[7], 16'h1235);
    checkOutput("mInc_d", d_dbg, 16'h1234);

    // D=-1 ; @10 ; D;JLT taken, then D=0 ; @10 ; D;JLT not taken
    applyStimulus(16'hEE90, 0, 0);
    applyStimulus(16'h000A, 0, 0);
    applyStimulus(16'hE304, 1, 0);
    checkOutput("jlt_taken_pc", pc_dbg, 15'd10);
    applyStimulus(16'hEA90, 0, 0);
    applyStimulus(16'h000A, 0, 0);
    applyStimulus(16'hE304, 0, 0);
    checkOutput("jlt_not_taken_pc", pc_dbg, 15'd13);

    // Random program with random response latencies
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      if (r[1:0] == 2'd0) begin
        instr = {1'b0, r[16:2]};
      end else begin
        jmp = r[4:2];
        if (mA[14:0] == mPc) jmp = 3'd0;
        instr = {1'b1, r[6:5], r[7], COMP_CODES[$urandom_range(0, 17)], r[10:8], jmp};
      end
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      rw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(instr, fw, rw);
    end

    // Reset while a data read is outstanding
    applyReset();
    applyStimulus(16'h0007, 0, 0);
    instr_valid = 1'b1;
    instr_data = 16'hFC10;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("mread_req", {mem_rd_req, mem_addr}, {1'b1, 15'd7});
    rst = 1'b1;
    #1;
    checkOutput("rst_async_outputs", outVec(), 0);
    checkOutput("rst_async_state", {pc_dbg, a_dbg}, 0);
    @(posedge clk);
    #1;
    mem_rvalid = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checkOutput("rst_hold_outputs", outVec(), 0);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    checkOutput("boot_no_req", instr_req, 1'b0);
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("first_fetch", {instr_req, instr_addr, mem_rd_req}, {1'b1, 15'd0, 1'b0});
    checkOutput("late_valid_ignored", {a_dbg, d_dbg}, 0);
    mA = 16'd0; mD = 16'd0; mPc = 15'd0;
    applyStimulus(16'h0003, 0, 0);
    applyStimulus(16'hEC10, 0, 0);

    // Self-loop: @3 ; 0;JMP at address 3
    applyReset();
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0003, 0, 0);
    applyStimulus(16'hEA87, 0, 0);
`ifdef HACK_ALU_SEQ_HALT_EN
    begin
      int reqSeen;
      reqSeen = 0;
      repeat (10) begin
        @(negedge clk);
        if (instr_req !== 1'b0 || halted !== 1'b1) reqSeen++;
      end
      checkOutput("halt_stays", reqSeen, 0);
      checkOutput("halt_outputs", outVec(), 88'd1);
    end
`else
    applyStimulus(16'hEA87, 0, 0);
    applyStimulus(16'hEA87, 1, 0);
    checkOutput("self_loop_pc", pc_dbg, 15'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_alu_seq.md
# hack_alu_seq

Multi-cycle Hack instruction sequencer that drives the 16-bit Hack ALU: it fetches instructions, holds the A, D and PC registers, and decodes each C-instruction into the six ALU control bits. It consumes the ALU's `result`, `zr` and `ng` for writeback and jump decisions. It sits between instruction ROM, data RAM and the existing ALU, and is the initiator side of the ALU's op/result interface.

## Interface
- No parameters; all widths are fixed by the Hack ISA.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_req` out 1: instruction fetch request.
- `instr_addr` out 15: fetch address, equal to PC.
- `instr_valid` in 1: `instr_data` valid this cycle.
- `instr_data` in 16: instruction word.
- `mem_rd_req` out 1: data read request.
- `mem_we` out 1: data write strobe, one cycle.
- `mem_addr` out 15: data address, equal to A[14:0].
- `mem_wdata` out 16: write data.
- `mem_rvalid` in 1: `mem_rdata` valid this cycle.
- `mem_rdata` in 16: read data.
- `alu_x` out 16: ALU x operand, always D.
- `alu_y` out 16: ALU y operand, A or M.
- `alu_op` out 6: bit order is [0]=zx, [1]=nx, [2]=zy, [3]=ny, [4]=f, [5]=no.
- `alu_result` in 16: ALU output, signed.
- `alu_zr` in 1: ALU zero flag.
- `alu_ng` in 1: ALU negative flag.
- `halted` out 1: halt indication (see Configuration).
- `pc_dbg` out 15, `a_dbg` out 16, `d_dbg` out 16: architectural state, for observation by the bench.

## Operation
- Registers: PC (15 bit), A (16 bit), D (16 bit), IR (16 bit), MR (16 bit, holds M), RES/ZR/NG (the captured ALU output).
- States:
  - **BOOT:** the reset state. Goes to FETCH on the first edge after `rst` falls.
  - **FETCH:** `instr_req`=1 and `instr_addr`=PC. Holds until `instr_valid`, then IR<=`instr_data` and the state moves to DECODE.
  - **DECODE:** if IR[15]=0, A<={1'b0,IR[14:0]}, PC<=PC+1, next FETCH. Else if IR[12]=1, next MREAD. Else next EXEC.
  - **MREAD:** `mem_rd_req`=1 and `mem_addr`=A[14:0]. Holds until `mem_rvalid`, then MR<=`mem_rdata`, next EXEC.
  - **EXEC:** `alu_x`=D and `alu_y`=IR[12] ? MR : A. `alu_op` = {IR[6],IR[7],IR[8],IR[9],IR[10],IR[11]}, so `alu_op[0]`=IR[11]. Captures RES, ZR, NG; next WB.
  - **WB:**
    - If IR[3]=1: `mem_we`=1, `mem_addr`=old A, `mem_wdata`=RES.
    - If IR[5]=1: A<=RES. If IR[4]=1: D<=RES.
    - Jump is taken when (IR[2]&NG) | (IR[1]&ZR) | (IR[0]&!NG&!ZR). If taken, PC<=old A[14:0]; else PC<=PC+1.
    - Next FETCH.
- "Old A" means the value of A before this instruction's writeback. Memory address and jump target both use old A, even when dest includes A.
- C-instruction bits IR[14:13] are ignored.
- PC wraps from 0x7FFF to 0x0000. The ALU wraps modulo 2^16.
- Outputs other than those listed for a state are 0 in that state. `alu_*` are driven only in EXEC and are 0 otherwise.

## Timing
- Reset: while `rst` is high and in BOOT, every output is 0. PC, A, D, IR and MR are all 0.
- Cycle counts with zero-wait responses (valid in the same cycle as the request):
  - A-instruction: 2 cycles (FETCH, DECODE).
  - C-instruction without M: 4 cycles.
  - C-instruction with M: 5 cycles.
  - Each wait cycle on `instr_valid` or `mem_rvalid` adds 1.
- `instr_valid` or `mem_rvalid` outside the matching request state is ignored.
- `mem_we` is high for exactly one cycle per M-destination instruction.
- A read and a write never occur in the same cycle.
- Reset mid-operation: asynchronous return to BOOT and all outputs 0 immediately. A pending fetch or read is abandoned; a late valid is ignored.

## Configuration
- Macro: `HACK_ALU_SEQ_HALT_EN`.
- Defined: in WB, a taken jump whose target equals the current PC enters state HALT.
  - In HALT, `halted`=1 and all other outputs are 0.
  - HALT is left only by reset.
- Undefined: the HALT state does not exist, `halted` is tied 0, and self-loops keep fetching.

## Test plan
- ROM[0]=0x0005 (@5), ROM[1]=0xEC10 (D=A) -> after 6 cycles: A=5, D=5, PC=2. `alu_op`=6'b000011 during EXEC.
- ROM[0]=0x0007, ROM[1]=0xFC10 (D=M), RAM[7]=0x1234 -> `mem_rd_req` with `mem_addr`=7. D=0x1234, PC=2.
- Continue with ROM[2]=0xE7C8 (M=D+1) -> one-cycle `mem_we` with `mem_addr`=7 and `mem_wdata`=0x1235. D unchanged.
- @10, then D;JLT (0xE304):
  - with D=0xFFFF -> PC=10.
  - with D=0 -> PC = instruction address + 1.
- Assert `rst` during MREAD with `mem_rvalid` withheld:
  - Outputs go 0 the same cycle and PC=0.
  - A `mem_rvalid` pulse during reset is ignored.
  - First `instr_req` (addr 0) appears in the second cycle after release.
- ROM[2]=0x0003, ROM[3]=0xEA87 (0;JMP):
  - With the macro defined, `halted`=1 and no further `instr_req`.
  - With it undefined, address 3 is refetched indefinitely.
